// File: rtl/ram_access_ctrl.sv
`timescale 1ns/1ps
// ram_access_ctrl: turns host read/write requests into 4002-style RAM bus frames (SRC, then WRM/RDM).
// Optional macro SRC_CACHE_EN skips the SRC frame when the address matches the last one sent.
module ram_access_ctrl #(
  parameter int BANK_W = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  inout  wire  [3:0]           data,
  output logic                 sync,
  output logic [2**BANK_W-1:0] cmd_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BANK_W+6:0]    req_addr,
  input  logic [3:0]           req_wdata,
  output logic                 rsp_valid,
  output logic [3:0]           rsp_rdata,
  output logic                 busy
);

  localparam logic [3:0] OP_WRM = 4'h0;
  localparam logic [3:0] OP_RDM = 4'h9;

  typedef enum logic [1:0] {IDLE, SRC, INST} state_t;

  state_t            state;
  logic [2:0]        cyc;
  logic [BANK_W-1:0] bank;
  logic              chip;
  logic [1:0]        reg_sel;
  logic [3:0]        char_sel;
  logic              we;
  logic [3:0]        wdata;
  logic [3:0]        data_out;
  logic              data_oe;
  logic              accept;
  logic              src_hit;

  assign data   = data_oe ? data_out : 4'bz;
  assign busy   = (state != IDLE);
  assign accept = req_valid && req_ready;

`ifdef SRC_CACHE_EN
  logic [BANK_W+6:0] last_src;
  logic              src_valid;

  assign src_hit = src_valid && (req_addr == last_src);

  // Remember the address of every SRC frame that ran to completion.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_src  <= '0;
      src_valid <= 1'b0;
    end else if (state == SRC && cyc == 3'd7) begin
      last_src  <= {bank, chip, reg_sel, char_sel};
      src_valid <= 1'b1;
    end
  end
`else
  assign src_hit = 1'b0;
`endif

  // Outputs are registered, so each bus action is scheduled one cycle ahead of its frame slot.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      cyc       <= 3'd0;
      sync      <= 1'b0;
      cmd_n     <= '1;
      data_out  <= 4'h0;
      data_oe   <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 4'h0;
      bank      <= '0;
      chip      <= 1'b0;
      reg_sel   <= 2'd0;
      char_sel  <= 4'h0;
      we        <= 1'b0;
      wdata     <= 4'h0;
    end else begin
      cyc       <= cyc + 3'd1;
      sync      <= (cyc == 3'd6);
      cmd_n     <= '1;
      data_oe   <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;

      if (accept) begin
        {bank, chip, reg_sel, char_sel} <= req_addr;
        we    <= req_we;
        wdata <= req_wdata;
      end

      case (state)
        IDLE: begin
          if (cyc == 3'd6) req_ready <= 1'b1;
          if (accept) state <= src_hit ? INST : SRC;
        end

        SRC: begin
          case (cyc)
            3'd5: begin
              cmd_n[bank] <= 1'b0;
              data_out    <= {1'b0, chip, reg_sel};
              data_oe     <= 1'b1;
            end
            3'd6: begin
              data_out <= char_sel;
              data_oe  <= 1'b1;
            end
            3'd7:    state <= INST;
            default: ;
          endcase
        end

        INST: begin
          case (cyc)
            3'd3: begin
              cmd_n[bank] <= 1'b0;
              data_out    <= we ? OP_WRM : OP_RDM;
              data_oe     <= 1'b1;
            end
            3'd5: begin
              if (we) begin
                data_out <= wdata;
                data_oe  <= 1'b1;
              end
            end
            // End of cyc 6: the RAM is driving the read nibble now.
            3'd6: begin
              req_ready <= 1'b1;
              if (!we) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= data;
              end
            end
            3'd7: begin
              if (accept) state <= src_hit ? INST : SRC;
              else        state <= IDLE;
            end
            default: ;
          endcase
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Bus sequencer that turns simple host read/write requests into 4-bit RAM bus transactions for the 4002-style RAM chips.
- Owns the shared 8-cycle frame counter and emits sync.
- Drives per-bank cmd_n strobes and the data bus: an SRC frame (chip/register/character select), then an instruction frame (WRM or RDM).
- Sits between the host/debug logic and up to four banks of two RAM chips each.

Parameters:
- BANK_W, 2, width of bank select; number of cmd_n lines = 2**BANK_W.

Ports:
- clock  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- data  inout  4  shared RAM data bus; high-Z when not driven
- sync  output  1  frame marker, high during cycle 7
- cmd_n  output  2**BANK_W  active-low per-bank command strobe
- req_valid  input  1  host request present
- req_ready  output  1  request accepted when valid&&ready
- req_we  input  1  1=write (WRM, opcode 4'h0), 0=read (RDM, opcode 4'h9)
- req_addr  input  BANK_W+7  {bank, chip, reg[1:0], char[3:0]}
- req_wdata  input  4  write nibble
- rsp_valid  output  1  one-cycle pulse, read data valid
- rsp_rdata  output  4  read nibble, held until next read completes
- busy  output  1  state != IDLE

Behaviour:
- Frame counter cyc[2:0]: 0 on reset, increments every clock, wraps 7->0. Matches the RAM chips' counter because both leave reset on the same edge.
- sync = (cyc==7) in every frame, regardless of state.
- Reset values: cmd_n all 1, data high-Z, req_ready 0, rsp_valid 0, rsp_rdata 0, busy 0, state IDLE. All latched request fields clear.
- Reset asserted mid-transaction aborts it with no response. Bus is released on the next clock.
- States: IDLE, SRC, INST.
- IDLE:
  - req_ready = (cyc==7); ready is low in all other cycles and states.
  - On handshake: latch addr/we/wdata, go to SRC at cyc 0.
- SRC frame, cyc 0..7:
  - cyc 6: cmd_n[bank]=0; data = {1'b0, chip, reg}.
  - cyc 7: cmd_n all 1; data = char.
  - End of cyc 7: go to INST.
- INST frame:
  - cyc 4: cmd_n[bank]=0; data = opcode.
  - cyc 6: cmd_n all 1. Write: data = wdata. Read: data high-Z, sample data into rsp_rdata.
  - cyc 7: rsp_valid=1 for reads only. req_ready=1, so a new request may be accepted on this same edge; otherwise return to IDLE.
- cmd_n is never low in any other cycle, and at most one bit is low at any time.
- data is driven only in the listed cycles; high-Z in all others.
- Latency: acceptance to rsp_valid = 16 clocks. Throughput is one access per 16 clocks.
- req_addr and req_wdata are sampled only at acceptance; later changes are ignored.
- A request arriving at cyc != 7 waits, with req_ready low, until the next cyc 7.

Optional Feature:
- Macro SRC_CACHE_EN.
- Defined:
  - Controller keeps last_src = {bank, chip, reg, char} and a valid bit.
  - An accepted request whose address equals last_src skips the SRC frame and goes straight to INST. Latency 8, throughput 8.
  - valid is cleared by reset and set after each completed SRC frame.
- Undefined: every access issues an SRC frame; no extra state is present.

Test Plan:
- Reset, then write addr {bank 1, chip 0, reg 2, char 5}, data 4'hA:
  - SRC cyc6: cmd_n=4'b1101, data=4'h2.
  - SRC cyc7: data=4'h5.
  - INST cyc4: cmd_n=4'b1101, data=4'h0.
  - INST cyc6: data=4'hA. No rsp_valid.
- Read of the same address with the RAM model attached:
  - INST cyc4: data=4'h9.
  - INST cyc7: rsp_valid=1, rsp_rdata=4'hA, 16 clocks after acceptance.
- req_valid raised at cyc 2:
  - req_ready stays low until cyc 7; accept there.
  - cmd_n all 1 and data Z during the wait.
- Two back-to-back reads held valid:
  - Second accepted at INST cyc 7 of the first.
  - rsp_valid pulses exactly 16 clocks apart; no idle frame in between.
- reset_n low at INST cyc 4 of a write:
  - Next clock: cmd_n all 1, data Z, state IDLE.
  - No rsp_valid, and the RAM location is unchanged.
- SRC_CACHE_EN defined, two reads to the same address:
  - Second read has no SRC frame; latency 8.
  - A third read with a different char issues SRC again.
